// File: rtl/tdm_mux8_if.sv
// Bundle of scan controls, channel data and serial outputs for tdm_mux8.
interface tdm_mux8_if;
  logic       en;
  logic [7:0] mask;
  logic [7:0] d;
  logic       w;
  logic [2:0] sel;
  logic       valid;
  logic       frame;

  modport master (output en, mask, d, input w, sel, valid, frame);
  modport slave  (input en, mask, d, output w, sel, valid, frame);
endinterface

// File: rtl/tdm_mux8.sv
// Round-robin 8-to-1 time-division multiplexer: each enabled channel is held
// on w/sel for DWELL cycles, with a frame pulse at the start of each scan.
module tdm_mux8 #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  tdm_mux8_if.slave  bus
);
  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             w_q, w_d;
  logic             valid_q, valid_d;
  logic             frame_q, frame_d;

  logic [2:0]       first_ch;
  logic [2:0]       next_ch;
  logic             mask_any;

  assign mask_any = |bus.mask;

  // Lowest enabled channel, and the next enabled one above sel_q (wrapping to the lowest).
  always_comb begin
    first_ch = 3'd0;
    next_ch  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.mask[i]) first_ch = 3'(i);
    end
    next_ch = first_ch;
    for (int i = 7; i >= 0; i--) begin
      if (bus.mask[i] && (3'(i) > sel_q)) next_ch = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    frame_d = 1'b0;
    w_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        sel_d   = 3'd0;
        valid_d = 1'b0;
        if (bus.en && mask_any) begin
          state_d = ST_SCAN;
          sel_d   = first_ch;
          valid_d = 1'b1;
          frame_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!bus.en || ((cnt_q == CNT_LAST) && !mask_any)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sel_d   = 3'd0;
          valid_d = 1'b0;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          // A new index at or below the old one means the scan wrapped.
          cnt_d   = '0;
          sel_d   = next_ch;
          frame_d = (next_ch <= sel_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        sel_d   = 3'd0;
        valid_d = 1'b0;
      end
    endcase
    // w follows the channel selected at this same edge so w and sel stay coherent.
    w_d = valid_d ? bus.d[sel_d] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
      w_q     <= 1'b0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      w_q     <= w_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
    end
  end

  assign bus.w     = w_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.frame = frame_q;
endmodule

// File: tb/tb_tdm_mux8.sv
// Bench for tdm_mux8: four instances (DWELL 1..4) share stimulus and are
// compared each cycle against a channel-scan reference model.
module tb_tdm_mux8;
  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] mask;
  logic [7:0] d;

  int checks;
  int passes;

  tdm_mux8_if bus0 ();
  tdm_mux8_if bus1 ();
  tdm_mux8_if bus2 ();
  tdm_mux8_if bus3 ();

  assign bus0.en = en;  assign bus0.mask = mask;  assign bus0.d = d;
  assign bus1.en = en;  assign bus1.mask = mask;  assign bus1.d = d;
  assign bus2.en = en;  assign bus2.mask = mask;  assign bus2.d = d;
  assign bus3.en = en;  assign bus3.mask = mask;  assign bus3.d = d;

  tdm_mux8 #(.DWELL(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  tdm_mux8 #(.DWELL(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  tdm_mux8 #(.DWELL(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  tdm_mux8 #(.DWELL(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Packed {w, sel, valid, frame} per instance.
  logic [5:0] act [4];
  assign act[0] = {bus0.w, bus0.sel, bus0.valid, bus0.frame};
  assign act[1] = {bus1.w, bus1.sel, bus1.valid, bus1.frame};
  assign act[2] = {bus2.w, bus2.sel, bus2.valid, bus2.frame};
  assign act[3] = {bus3.w, bus3.sel, bus3.valid, bus3.frame};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which channel is on air and how many cycles it has had.
  int   dw     [4] = '{1, 2, 3, 4};
  bit   m_on   [4];
  int   m_sel  [4];
  int   m_age  [4];
  bit   m_frame[4];
  bit   m_w    [4];

  function automatic int next_on(input logic [7:0] m, input int cur);
    for (int k = 1; k <= 8; k++) begin
      if (m[(cur + k) % 8]) return (cur + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset_all();
    for (int k = 0; k < 4; k++) begin
      m_on[k] = 0; m_sel[k] = 0; m_age[k] = 0; m_frame[k] = 0; m_w[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int nx;
    if (rst) begin
      m_on[k] = 0; m_sel[k] = 0; m_age[k] = 0; m_frame[k] = 0;
    end else begin
      m_frame[k] = 0;
      if (!m_on[k]) begin
        if (en && mask != 8'h00) begin
          m_on[k] = 1; m_sel[k] = next_on(mask, 7); m_age[k] = 1; m_frame[k] = 1;
        end
      end else if (!en) begin
        m_on[k] = 0;
      end else if (m_age[k] < dw[k]) begin
        m_age[k]++;
      end else begin
        nx = next_on(mask, m_sel[k]);
        if (nx < 0) m_on[k] = 0;
        else begin
          m_frame[k] = (nx <= m_sel[k]);
          m_sel[k] = nx;
          m_age[k] = 1;
        end
      end
    end
    m_w[k] = m_on[k] ? d[m_sel[k]] : 1'b0;
  endtask

  function automatic logic [5:0] expv(input int k);
    return {m_w[k], m_on[k] ? 3'(m_sel[k]) : 3'd0, m_on[k], m_frame[k]};
  endfunction

  task automatic check(input string name, input logic [5:0] actual, input logic [5:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("FAIL %s: got w,sel,valid,frame=%b required %b at %0t", name, actual, expected, $time);
  endtask

  task automatic check_model_all();
    for (int k = 0; k < 4; k++) check($sformatf("model_dwell%0d", k + 1), act[k], expv(k));
  endtask

  // One clock: step the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 4; k++) model_step(k);
    #1;
    check_model_all();
  endtask

  task automatic do_reset();
    en = 1'b0;
    rst = 1'b1;
    tick();
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [7:0] mask;
    logic [7:0] d;
    logic [2:0] sel;
    logic       w;
    logic       valid;
    logic       frame;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic [15:0] wexp;
    int guard;
    checks = 0;
    passes = 0;
    rst = 1'b1; en = 1'b0; mask = 8'h00; d = 8'h00;
    model_reset_all();

    // Frame of DWELL=2 over all channels with d=A5.
    wexp = 16'b1100_1100_0011_0011;
    for (int i = 0; i < 17; i++) begin
      tbl[i].en    = 1'b1;
      tbl[i].mask  = 8'hFF;
      tbl[i].d     = 8'hA5;
      tbl[i].sel   = 3'((i / 2) % 8);
      tbl[i].w     = wexp[15 - (i % 16)];
      tbl[i].valid = 1'b1;
      tbl[i].frame = ((i % 16) == 0);
    end

    tick();
    for (int k = 0; k < 4; k++) check($sformatf("reset_dwell%0d", k + 1), act[k], 6'b0);
    #2;
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      en = tbl[i].en; mask = tbl[i].mask; d = tbl[i].d;
      tick();
      check($sformatf("tbl_dw2_row%0d", i), act[1],
            {tbl[i].w, tbl[i].sel, tbl[i].valid, tbl[i].frame});
    end

    // Two-channel mask at DWELL=3.
    do_reset();
    mask = 8'h24; d = 8'h20; en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      check($sformatf("two_ch_dw3_c%0d", c), act[2],
            {((c / 3) % 2) == 1, ((c / 3) % 2) == 1 ? 3'd5 : 3'd2, 1'b1, (c % 6) == 0});
    end

    // Empty mask keeps everything idle; then a single high channel.
    do_reset();
    mask = 8'h00; en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      for (int k = 0; k < 4; k++) check($sformatf("empty_mask_dwell%0d", k + 1), act[k], 6'b0);
    end
    mask = 8'h80;
    for (int c = 0; c < 9; c++) begin
      tick();
      check("single_ch_dw1", act[0], {1'b0, 3'd7, 1'b1, 1'b1});
    end

    // Asynchronous reset in the middle of channel 3's dwell.
    do_reset();
    mask = 8'hFF; en = 1'b1;
    for (int c = 0; c < 14; c++) tick();
    check("pre_rst_sel3", act[3], {d[3], 3'd3, 1'b1, 1'b0});
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("async_rst_dwell%0d", k + 1), act[k], 6'b0);
    model_reset_all();
    #2;
    rst = 1'b0;
    tick();
    check("restart_after_rst", act[3], {d[0], 3'd0, 1'b1, 1'b1});

    // Clear channel 4 mid-dwell: it finishes, then is skipped next frame.
    for (int c = 0; c < 17; c++) tick();
    check("ch4_cnt1", act[3], {d[4], 3'd4, 1'b1, 1'b0});
    mask = 8'hEF;
    tick();
    tick();
    check("ch4_last", act[3], {d[4], 3'd4, 1'b1, 1'b0});
    tick();
    check("ch4_to_ch5", act[3], {d[5], 3'd5, 1'b1, 1'b0});
    for (int c = 0; c < 27; c++) tick();
    check("ch3_before_skip", act[3], {d[3], 3'd3, 1'b1, 1'b0});
    tick();
    check("skip_ch4", act[3], {d[5], 3'd5, 1'b1, 1'b0});

    // Drop en on channel 6, then re-enable.
    guard = 0;
    while (!(m_on[3] && m_sel[3] == 6) && guard < 40) begin
      tick();
      guard++;
    end
    check("reach_ch6", act[3], {d[6], 3'd6, 1'b1, 1'b0});
    en = 1'b0;
    tick();
    check("en_drop", act[3], 6'b0);
    en = 1'b1;
    tick();
    check("en_reraise", act[3], {d[0], 3'd0, 1'b1, 1'b1});

    // Randomized traffic with occasional mask changes and async resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 9);
        if (r == 0)      mask = 8'h00;
        else if (r <= 3) mask = 8'(1 << $urandom_range(0, 7));
        else             mask = 8'($urandom);
      end
      d = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset_all();
        check_model_all();
        #1;
        rst = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/tdm_mux8.md
# tdm_mux8

Sequential 8-to-1 time-division multiplexer, the transmit-side counterpart of the 1-to-8 demultiplexer. It scans eight 1-bit input channels and presents one at a time on a single serial line `w`, together with the 3-bit channel index `sel`. A downstream 1-to-8 demux driven by the same `w`/`sel` pair rebuilds the parallel channels. Scan order is round-robin, each channel is held for a programmable dwell time, and channels disabled by a mask are skipped.

## Interface
Parameters:
- `DWELL`, default 4: clock cycles spent on each enabled channel; legal range 1..256.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  scan enable; while low the block idles.
- `mask`  input  8  channel enable; bit i = 1 includes channel i in the scan.
- `d`  input  8  parallel channel data; bit i is channel i.
- `w`  output  1  serialized data, registered: the value of `d[sel]`.
- `sel`  output  3  index of the channel currently on `w`, registered.
- `valid`  output  1  high while `w`/`sel` carry a scanned channel.
- `frame`  output  1  one-cycle pulse on the first cycle of the first channel of each scan frame.

## Operation
- States: IDLE and SCAN. Internal dwell counter `cnt` runs 0..DWELL-1.
- Reset (asynchronous, takes effect immediately mid-operation): state = IDLE, `w`=0, `sel`=0, `valid`=0, `frame`=0, `cnt`=0.
- IDLE: `w`=0, `sel`=0, `valid`=0, `frame`=0.
  - At an edge with `en`=1 and `mask`≠0, go to SCAN.
  - `sel` is loaded with the lowest set bit of `mask`, `cnt`=0, `valid`=1, `frame`=1.
- SCAN, every edge:
  - `w` <= `d[sel_next]`, where `sel_next` is the value `sel` takes at that edge.
  - If `cnt` < DWELL-1: `cnt` increments, `sel` holds, `frame`=0.
  - If `cnt` = DWELL-1: `cnt`=0 and `sel` advances to the next set bit of `mask` strictly above the current `sel`, wrapping past 7 to the lowest set bit.
  - A wrap, meaning the new index ≤ the old index (this includes the single-channel mask), sets `frame`=1 for that one cycle.
- Mask changes: `mask` is sampled only when choosing the next channel. A channel cleared mid-dwell finishes its dwell.
- `en`=0, or `mask`=0 at a channel-advance edge, while in SCAN: return to IDLE at that edge with outputs as in IDLE.
  - `en` low takes effect at any edge.
  - `mask`=0 is acted on only at an advance edge; until then the current dwell continues.
- Simultaneous `en` rise and `mask`=0: the block stays in IDLE.

## Timing
- Latency: `w` reflects `d` sampled at the previous rising edge, so `w` lags `d` by one clock. `sel`, `w`, `valid` and `frame` always update on the same edge, so `w` and `sel` are coherent.
- From the `en` rise edge, the first valid output is visible in the following cycle.
- Each enabled channel occupies exactly DWELL consecutive cycles.
- The frame period is N×DWELL cycles, where N = popcount(`mask`).
- DWELL=1: `sel` changes every cycle; `frame` is asserted on every cycle when N=1.
- No combinational path from inputs to outputs.

## Test plan
- DWELL=2, `mask`=8'hFF, `d`=8'b1010_0101, raise `en` → `sel` steps 0,0,1,1,…,7,7,0. `w` is 1,1,0,0,1,1,0,0,0,0,1,1,0,0,1,1 across the frame. `frame`=1 only on the first cycle at `sel`=0 (cycles 1 and 17). `valid`=1 throughout.
- DWELL=3, `mask`=8'b0010_0100, `d`=8'h20 → `sel` sequence 2,2,2,5,5,5,2,…. `w`=0 on channel 2 and 1 on channel 5. `frame` pulses when entering channel 2.
- `mask`=8'h00 with `en`=1 → `valid`, `w`, `sel` and `frame` stay 0 indefinitely. Then set `mask`=8'h80 → `sel`=7 and `frame`=1 on every dwell start.
- Mid-dwell on `sel`=3 (DWELL=4, `mask`=8'hFF), assert `rst` asynchronously between edges → all outputs go to 0 before the next edge. After `rst` falls with `en`=1, the scan restarts at `sel`=0 with `frame`=1.
- DWELL=4, clear `mask` bit 4 while `sel`=4 at `cnt`=1 → channel 4 completes its 4 cycles, then `sel`=5. On the following frame, 4 is skipped (3→5).
- Drop `en` while `sel`=6 → at the next edge `valid`=0, `sel`=0, `w`=0. Re-raise `en` → the scan restarts at the lowest enabled channel with `frame`=1.
